// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - one acquisition frame into circular sample RAM
//
// Purpose: sequences pre-trigger fill (ARM), trigger wait (WAIT), post-trigger
// capture (POST) and display handoff (DONE) for the circular sample RAM.
// Optional feature macro: HOLDOFF_EN adds a HOLDOFF idle period after an
// acknowledged frame before re-arming in run mode.
//
// Ports:
//   clk_25, rst_n      clock, asynchronous active-low reset
//   run, single        continuous-run level / one-frame arm pulse
//   trig_in            trigger level, rising edge used
//   auto_mode          force a trigger after AUTO_TIMEOUT cycles in WAIT
//   sample_valid       ADC sample strobe
//   pretrig_len        pre-trigger sample count, latched on ARM entry
//   frame_ack          display reader has consumed the frame
//   wr_en, wr_addr     RAM write strobe and address
//   trig_addr          address of the first post-trigger sample
//   frame_ready        complete frame in RAM
//   forced             current/last frame was auto-forced
//   busy, state        activity flag and debug state
module capture_sequencer #(
    parameter int ADDR_W         = 9,
    parameter int AUTO_TIMEOUT   = 2**20,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              run,
    input  logic              single,
    input  logic              trig_in,
    input  logic              auto_mode,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              frame_ready,
    output logic              forced,
    output logic              busy,
    output logic [2:0]        state
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam int              TMO_W    = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4,
        S_HOLDOFF = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              trig_in_d_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic              one_shot_q, one_shot_d;
    // ARM: writes so far; POST: writes still to go
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              frame_ready_q, frame_ready_d;
    logic              forced_q, forced_d;
`ifdef HOLDOFF_EN
    localparam int              HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
    logic [HO_W-1:0]   ho_q, ho_d;
`endif

    logic              trig_rise;
    logic              timeout;
    logic              abort;
    logic              enter_arm;
    logic [ADDR_W:0]   post_len;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            trig_in_d_q   <= 1'b0;
            wr_addr_q     <= '0;
            trig_addr_q   <= '0;
            pre_len_q     <= '0;
            one_shot_q    <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            frame_ready_q <= 1'b0;
            forced_q      <= 1'b0;
`ifdef HOLDOFF_EN
            ho_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            trig_in_d_q   <= trig_in;
            wr_addr_q     <= wr_addr_d;
            trig_addr_q   <= trig_addr_d;
            pre_len_q     <= pre_len_d;
            one_shot_q    <= one_shot_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            frame_ready_q <= frame_ready_d;
            forced_q      <= forced_d;
`ifdef HOLDOFF_EN
            ho_q          <= ho_d;
`endif
        end
    end

    always_comb begin
        wr_en     = sample_valid & ((state_q == S_ARM) | (state_q == S_WAIT) | (state_q == S_POST));
        trig_rise = trig_in & ~trig_in_d_q;
        timeout   = auto_mode & (tmo_q == TMO_LAST);
        // One-shot frames run with run low, so only a continuous run aborts.
        abort     = ~run & ~one_shot_q;
        // A sample written in the trigger cycle is already the first post sample.
        post_len  = DEPTH_V - {1'b0, pre_len_q} - {{ADDR_W{1'b0}}, wr_en};

        state_d       = state_q;
        wr_addr_d     = wr_en ? wr_addr_q + 1'b1 : wr_addr_q;
        trig_addr_d   = trig_addr_q;
        pre_len_d     = pre_len_q;
        one_shot_d    = one_shot_q;
        cnt_d         = cnt_q;
        tmo_d         = '0;
        frame_ready_d = frame_ready_q;
        forced_d      = forced_q;
        enter_arm     = 1'b0;
`ifdef HOLDOFF_EN
        ho_d          = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (run | single) begin
                    state_d    = S_ARM;
                    enter_arm  = 1'b1;
                    one_shot_d = single & ~run;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pre_len_q == '0) begin
                    state_d = S_WAIT;
                end else if (wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == {1'b0, pre_len_q}) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (trig_rise | timeout) begin
                    trig_addr_d = wr_addr_q;
                    forced_d    = ~trig_rise;
                    cnt_d       = post_len;
                    if (post_len == '0) begin
                        state_d       = S_DONE;
                        frame_ready_d = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (wr_en) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d       = S_DONE;
                        frame_ready_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (frame_ack) begin
                    frame_ready_d = 1'b0;
                    if (run & ~one_shot_q) begin
`ifdef HOLDOFF_EN
                        state_d   = S_HOLDOFF;
`else
                        state_d   = S_ARM;
                        enter_arm = 1'b1;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef HOLDOFF_EN
            S_HOLDOFF: begin
                ho_d = ho_q + 1'b1;
                if (~run) begin
                    state_d = S_IDLE;
                end else if (ho_q == HO_LAST) begin
                    state_d   = S_ARM;
                    enter_arm = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (enter_arm) begin
            pre_len_d = pretrig_len;
            cnt_d     = '0;
        end
    end

    assign wr_addr     = wr_addr_q;
    assign trig_addr   = trig_addr_q;
    assign frame_ready = frame_ready_q;
    assign forced      = forced_q;
    assign busy        = (state_q != S_IDLE);
    assign state       = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
module tb_capture_sequencer;
    localparam int DEPTH = 16;

    logic       clk_25 = 1'b0;
    logic       rst_n, run, single, trig_in, auto_mode, sample_valid, frame_ack;
    logic [3:0] pretrig_len;
    logic       wr_en, frame_ready, forced, busy;
    logic [3:0] wr_addr, trig_addr;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int exp_addr = 0;

    always #5 clk_25 = ~clk_25;

    capture_sequencer #(
        .ADDR_W(4), .AUTO_TIMEOUT(100), .HOLDOFF_CYCLES(8)
    ) dut (
        .clk_25(clk_25), .rst_n(rst_n), .run(run), .single(single),
        .trig_in(trig_in), .auto_mode(auto_mode), .sample_valid(sample_valid),
        .pretrig_len(pretrig_len), .frame_ack(frame_ack), .wr_en(wr_en),
        .wr_addr(wr_addr), .trig_addr(trig_addr), .frame_ready(frame_ready),
        .forced(forced), .busy(busy), .state(state)
    );

    // Inputs change on the falling edge; outputs are observed 1 ns later.
    task automatic drive(input logic r, input logic s, input logic t, input logic v, input logic a);
        @(negedge clk_25);
        run = r; single = s; trig_in = t; sample_valid = v; frame_ack = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; single = 1'b0; trig_in = 1'b0; auto_mode = 1'b0;
        sample_valid = 1'b1; frame_ack = 1'b0; pretrig_len = 4'd4;
        repeat (2) @(negedge clk_25);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL reset_trig_addr got %0d want 0", trig_addr); end
        checks++; if ({frame_ready, forced, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_ready, forced, busy}); end
        @(negedge clk_25);
        rst_n = 1'b1; sample_valid = 1'b0;
        exp_addr = 0;
    endtask

    // Randomised frames: the model counts writes and derives every frame
    // boundary and address from pre/post sample counts.
    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            int p, d, arm_w, post_left, exp_trig;
            logic sv;
            p = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, 12);
            pretrig_len = 4'(p);
            drive(1, 0, 0, 0, 0);
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL rf_idle got %0d want 0", state); end
            arm_w = 0;
            do begin
                sv = ($urandom_range(0, 3) != 0);
                drive(1, 0, 0, sv, 0);
                pretrig_len = 4'($urandom);
                checks++; if (state !== 3'd1) begin errors++; $display("FAIL rf_arm_state got %0d want 1", state); end
                checks++; if (wr_en !== sv) begin errors++; $display("FAIL rf_arm_wr_en got %b want %b", wr_en, sv); end
                if (sv) begin
                    checks++; if (wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL rf_arm_addr got %0d want %0d", wr_addr, exp_addr); end
                    exp_addr = (exp_addr + 1) % DEPTH;
                    arm_w++;
                end
            end while (p != 0 && arm_w < p);
            for (int i = 0; i <= d; i++) begin
                sv = ($urandom_range(0, 3) != 0);
                drive(1, 0, (i == d), sv, 0);
                checks++; if (state !== 3'd2) begin errors++; $display("FAIL rf_wait_state got %0d want 2", state); end
                checks++; if (wr_en !== sv) begin errors++; $display("FAIL rf_wait_wr_en got %b want %b", wr_en, sv); end
                if (i == d) begin
                    exp_trig  = exp_addr;
                    post_left = DEPTH - p - (sv ? 1 : 0);
                end
                if (sv) begin
                    checks++; if (wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL rf_wait_addr got %0d want %0d", wr_addr, exp_addr); end
                    exp_addr = (exp_addr + 1) % DEPTH;
                end
            end
            for (int i = 0; i < 400 && post_left > 0; i++) begin
                sv = ($urandom_range(0, 3) != 0);
                drive(1, 0, 0, sv, 0);
                checks++; if (state !== 3'd3) begin errors++; $display("FAIL rf_post_state got %0d want 3", state); end
                checks++; if (wr_en !== sv) begin errors++; $display("FAIL rf_post_wr_en got %b want %b", wr_en, sv); end
                if (sv) begin
                    checks++; if (wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL rf_post_addr got %0d want %0d", wr_addr, exp_addr); end
                    exp_addr = (exp_addr + 1) % DEPTH;
                    post_left--;
                end
            end
            drive(1, 0, 0, 1, 0);
            checks++; if (state !== 3'd4) begin errors++; $display("FAIL rf_done_state got %0d want 4", state); end
            checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL rf_frame_ready got %b want 1", frame_ready); end
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rf_done_wr_en got %b want 0", wr_en); end
            checks++; if (trig_addr !== 4'(exp_trig)) begin errors++; $display("FAIL rf_trig_addr got %0d want %0d", trig_addr, exp_trig); end
            checks++; if (forced !== 1'b0) begin errors++; $display("FAIL rf_forced got %b want 0", forced); end
            drive(0, 0, 0, 1, 1);
            checks++; if (state !== 3'd4) begin errors++; $display("FAIL rf_ack_state got %0d want 4", state); end
            drive(0, 0, 0, 0, 0);
            checks++; if ({state, frame_ready, busy} !== 5'b000_0_0) begin errors++; $display("FAIL rf_after_ack got state %0d ready %b busy %b want 0 0 0", state, frame_ready, busy); end
        end
    endtask

    task automatic test_arm_trigger_ignored();
        pretrig_len = 4'd4;
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, (i == 1), 1, 0);
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL at_arm_state got %0d want 1", state); end
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 1, 0);
            checks++; if (state !== 3'd2 || frame_ready !== 1'b0) begin errors++; $display("FAIL at_wait got state %0d ready %b want 2 0", state, frame_ready); end
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        drive(0, 0, 0, 1, 0);
        exp_addr = (exp_addr + 1) % DEPTH;
        drive(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL at_abort_state got %0d want 0", state); end
        checks++; if (wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL at_abort_addr got %0d want %0d", wr_addr, exp_addr); end
    endtask

    task automatic test_auto_timeout();
        auto_mode = 1'b1;
        pretrig_len = 4'd4;
        for (int pass = 0; pass < 2; pass++) begin
            int exp_trig;
            drive(1, 0, 0, 1, 0);
            for (int i = 0; i < 4; i++) begin
                drive(1, 0, 0, 1, 0);
                exp_addr = (exp_addr + 1) % DEPTH;
            end
            for (int k = 0; k < 100; k++) begin
                drive(1, 0, (pass == 1 && k == 99), 1, 0);
                checks++; if (state !== 3'd2) begin errors++; $display("FAIL to_wait_state pass %0d cycle %0d got %0d want 2", pass, k, state); end
                if (k == 99) exp_trig = exp_addr;
                exp_addr = (exp_addr + 1) % DEPTH;
            end
            drive(1, 0, 0, 1, 0);
            checks++; if (state !== 3'd3) begin errors++; $display("FAIL to_post_state pass %0d got %0d want 3", pass, state); end
            checks++; if (forced !== (pass == 0)) begin errors++; $display("FAIL to_forced pass %0d got %b want %b", pass, forced, (pass == 0)); end
            checks++; if (trig_addr !== 4'(exp_trig)) begin errors++; $display("FAIL to_trig_addr got %0d want %0d", trig_addr, exp_trig); end
            exp_addr = (exp_addr + 1) % DEPTH;
            for (int i = 0; i < 10; i++) begin
                drive(1, 0, 0, 1, 0);
                exp_addr = (exp_addr + 1) % DEPTH;
            end
            drive(1, 0, 0, 1, 0);
            checks++; if (state !== 3'd4 || frame_ready !== 1'b1) begin errors++; $display("FAIL to_done got state %0d ready %b want 4 1", state, frame_ready); end
            drive(0, 0, 0, 0, 1);
            drive(0, 0, 0, 0, 0);
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL to_idle got %0d want 0", state); end
        end
        auto_mode = 1'b0;
    endtask

    task automatic test_single();
        int exp_trig;
        pretrig_len = 4'd4;
        drive(0, 1, 0, 1, 0);
        checks++; if (state !== 3'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL sg_idle got state %0d wr_en %b want 0 0", state, wr_en); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL sg_arm_state got %0d want 1", state); end
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, (i == 3), 1, 0);
            checks++; if (state !== 3'd2) begin errors++; $display("FAIL sg_wait_state got %0d want 2", state); end
            if (i == 3) exp_trig = exp_addr;
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        for (int i = 0; i < 11; i++) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (state !== 3'd3 || wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL sg_post got state %0d addr %0d want 3 %0d", state, wr_addr, exp_addr); end
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        drive(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd4 || frame_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sg_done got state %0d ready %b busy %b want 4 1 1", state, frame_ready, busy); end
        checks++; if (trig_addr !== 4'(exp_trig)) begin errors++; $display("FAIL sg_trig_addr got %0d want %0d", trig_addr, exp_trig); end
        drive(0, 1, 0, 1, 0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL sg_done_wr_en got %b want 0", wr_en); end
        drive(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd4 || frame_ready !== 1'b1) begin errors++; $display("FAIL sg_single_ignored got state %0d ready %b want 4 1", state, frame_ready); end
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd0 || busy !== 1'b0 || frame_ready !== 1'b0) begin errors++; $display("FAIL sg_after_ack got state %0d busy %b ready %b want 0 0 0", state, busy, frame_ready); end
    endtask

    task automatic test_rearm();
        pretrig_len = 4'd0;
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL ra_arm0_state got %0d want 1", state); end
        exp_addr = (exp_addr + 1) % DEPTH;
        drive(1, 0, 1, 1, 0);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL ra_wait_state got %0d want 2", state); end
        exp_addr = (exp_addr + 1) % DEPTH;
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 0, 1, 0);
            exp_addr = (exp_addr + 1) % DEPTH;
        end
        pretrig_len = 4'd4;
        drive(1, 0, 0, 1, 0);
        checks++; if (state !== 3'd4 || frame_ready !== 1'b1) begin errors++; $display("FAIL ra_done got state %0d ready %b want 4 1", state, frame_ready); end
        drive(1, 0, 0, 1, 1);
`ifdef HOLDOFF_EN
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1, 0);
            checks++; if (state !== 3'd5 || wr_en !== 1'b0) begin errors++; $display("FAIL ra_holdoff cycle %0d got state %0d wr_en %b want 5 0", i, state, wr_en); end
        end
`endif
        drive(1, 0, 0, 1, 0);
        checks++; if (state !== 3'd1 || wr_en !== 1'b1) begin errors++; $display("FAIL ra_rearm got state %0d wr_en %b want 1 1", state, wr_en); end
        checks++; if (wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL ra_rearm_addr got %0d want %0d", wr_addr, exp_addr); end
        exp_addr = (exp_addr + 1) % DEPTH;
        drive(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL ra_prelen_relatch got %0d want 1", state); end
        exp_addr = (exp_addr + 1) % DEPTH;
        drive(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL ra_abort got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_post();
        pretrig_len = 4'd4;
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL rp_in_post got %0d want 3", state); end
        @(negedge clk_25);
        rst_n = 1'b0; trig_in = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL rp_reset got state %0d wr_en %b want 0 0", state, wr_en); end
        checks++; if (wr_addr !== 4'd0 || frame_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rp_reset_regs got addr %0d ready %b busy %b want 0 0 0", wr_addr, frame_ready, busy); end
        exp_addr = 0;
        @(negedge clk_25);
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 0);
        checks++; if (state !== 3'd1 || wr_addr !== 4'(exp_addr)) begin errors++; $display("FAIL rp_rearm got state %0d addr %0d want 1 %0d", state, wr_addr, exp_addr); end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rp_final_idle got %0d want 0", state); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_random_frames();
        test_arm_trigger_ignored();
        test_auto_timeout();
        test_single();
        test_rearm();
        test_reset_mid_post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
